// File: rtl/reference_timestamper_pkg.sv
// reference_timestamper_pkg
// Shared types and constants for reference_timestamper and its record FIFO.
//   state_e          : capture state machine (PRIME -> RUN).
//   DROP_COUNT_WIDTH : width of the optional dropped-record counter.
//   sat_inc_drop     : saturating increment for the dropped-record counter.
// The {time, data} record depends on module parameters. It is therefore
// declared as a packed struct inside reference_timestamper, which owns those
// parameters.
package reference_timestamper_pkg;

    typedef enum logic [0:0] {
        PRIME,
        RUN
    } state_e;

    localparam int unsigned DROP_COUNT_WIDTH = 32;

    function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc_drop(
        input logic [DROP_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + DROP_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/timestamp_fifo.sv
// timestamp_fifo
// Synchronous record FIFO. A push is accepted on a full FIFO when a pop
// happens in the same cycle. The head is presented combinationally, so a
// record pushed into an empty FIFO is visible one cycle after its push.
// When the FIFO is empty, rdata_o holds the last popped record. It reads 0
// after reset.
// Ports:
//   clock, reset : clock and asynchronous active-low reset
//   push_i       : write wdata_i (caller guarantees !full_o || pop_i)
//   pop_i        : remove the head (caller guarantees !empty_o)
//   wdata_i      : record to write
//   rdata_o      : head record, or the last popped record when empty
//   full_o       : FIFO is full
//   empty_o      : FIFO is empty
module timestamp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage is not reset. A slot can be read only after it has been written.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/reference_timestamper.sv
// reference_timestamper
// Samples d on every rising clock edge and keeps a free-running timestamp
// `now`. It queues a {now, d} record whenever d differs from the previous
// sample. The first cycle after reset always queues a priming record at
// time 0. Records drain through a valid/ready port.
// Ports:
//   clock, reset  : clock and asynchronous active-low reset
//   d             : observed signal
//   out_valid     : head record available
//   out_ready     : consumer accepts the head record
//   out_time      : timestamp of the head record
//   out_data      : value of the head record
//   overflow      : sticky; at least one record was dropped
//   time_wrapped  : sticky; the timestamp counter has wrapped
//   dropped_count : saturating count of dropped records. This port exists
//                   only when REFERENCE_TIMESTAMPER_DROP_COUNT_EN is defined.
module reference_timestamper
    import reference_timestamper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned TIME_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TIME_WIDTH-1:0] out_time,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  overflow,
    output logic                  time_wrapped
`ifdef REFERENCE_TIMESTAMPER_DROP_COUNT_EN
    ,
    output logic [DROP_COUNT_WIDTH-1:0] dropped_count
`endif
);
    typedef struct packed {
        logic [TIME_WIDTH-1:0] ts;
        logic [DATA_WIDTH-1:0] data;
    } record_t;

    state_e                state_q, state_d;
    logic [TIME_WIDTH-1:0] now_q, now_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  overflow_q, overflow_d;
    logic                  wrapped_q, wrapped_d;

    logic    push_req, push, pop, drop;
    logic    fifo_full, fifo_empty;
    record_t wr_rec, rd_rec;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // PRIME captures the initial value unconditionally.
    assign push_req  = (state_q == PRIME) || (d != prev_q);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign drop      = push_req && fifo_full && !pop;
    assign push      = push_req && !drop;
    assign wr_rec    = '{ts: now_q, data: d};

    always_comb begin
        state_d    = RUN;
        now_d      = now_q + TIME_WIDTH'(1);
        prev_d     = d;
        overflow_d = overflow_q | drop;
        wrapped_d  = wrapped_q | (&now_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= PRIME;
            now_q      <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            now_q      <= now_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
            wrapped_q  <= wrapped_d;
        end
    end

    timestamp_fifo #(
        .WIDTH (TIME_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (rd_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_time     = rd_rec.ts;
    assign out_data     = rd_rec.data;
    assign overflow     = overflow_q;
    assign time_wrapped = wrapped_q;

`ifdef REFERENCE_TIMESTAMPER_DROP_COUNT_EN
    logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop ? sat_inc_drop(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropped_count = drop_cnt_q;
`endif

endmodule
